// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEMWAIT  = 2'd1,
      ST_EXCFLUSH = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO        = 5'd0;
   localparam int         MEM_TIMEOUT_DEF = 255;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_exe_en;
      logic exe_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_exe_flush;
      logic exe_mem_flush;
      logic mem_wb_flush;
      logic exc_ack;
      logic bus_err;
   } ctrl_t;

   function automatic ctrl_t ctrl_run_default();
      ctrl_t c;
      c = '{pc_en: 1'b1, if_id_en: 1'b1, id_exe_en: 1'b1, exe_mem_en: 1'b1, mem_wb_en: 1'b1,
            if_id_flush: 1'b0, id_exe_flush: 1'b0, exe_mem_flush: 1'b0, mem_wb_flush: 1'b0,
            exc_ack: 1'b0, bus_err: 1'b0};
      return c;
   endfunction

   function automatic ctrl_t ctrl_reset();
      ctrl_t c;
      c = '{pc_en: 1'b0, if_id_en: 1'b0, id_exe_en: 1'b0, exe_mem_en: 1'b0, mem_wb_en: 1'b0,
            if_id_flush: 1'b1, id_exe_flush: 1'b1, exe_mem_flush: 1'b1, mem_wb_flush: 1'b1,
            exc_ack: 1'b0, bus_err: 1'b0};
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse_cmp.sv
// Combinational load-use match between the load in EXE and the source registers read in ID.
module hazard_loaduse_cmp
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_use_rs_i,
   input  logic       id_use_rt_i,
   input  logic [4:0] exe_wb_dreg_i,
   input  logic       exe_wb_we_i,
   input  logic       exe_is_load_i,
   output logic       hit_o
);

   logic rs_match_s;
   logic rt_match_s;

   assign rs_match_s = id_use_rs_i && (id_rs_i == exe_wb_dreg_i);
   assign rt_match_s = id_use_rt_i && (id_rt_i == exe_wb_dreg_i);
   // $zero is never really written, so a load targeting it cannot create a hazard
   assign hit_o      = exe_is_load_i && exe_wb_we_i && (exe_wb_dreg_i != REG_ZERO)
                       && (rs_match_s || rt_match_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline enable/flush controller: exceptions, memory waits, branches, load-use interlock.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int TO_W        = 8,
   parameter int PERF_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [4:0]        exe_wb_dreg,
   input  logic              exe_wb_we,
   input  logic              exe_is_load,
   input  logic              exe_bj,
   input  logic              exc_req,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_exe_en,
   output logic              exe_mem_en,
   output logic              mem_wb_en,
   output logic              if_id_flush,
   output logic              id_exe_flush,
   output logic              exe_mem_flush,
   output logic              mem_wb_flush,
   output logic              exc_ack,
   output logic              bus_err,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] flush_events
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   ctrl_t           ctrl_s;
   logic            lu_hit_s;
   logic            eval_s;
   logic            exc_ok_s;

   hazard_loaduse_cmp u_lu_cmp (
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .id_use_rs_i   (id_use_rs),
      .id_use_rt_i   (id_use_rt),
      .exe_wb_dreg_i (exe_wb_dreg),
      .exe_wb_we_i   (exe_wb_we),
      .exe_is_load_i (exe_is_load),
      .hit_o         (lu_hit_s)
   );

   // Next state and Mealy control outputs from registered state and current requests
   always_comb begin
      ctrl_s   = ctrl_run_default();
      state_d  = state_q;
      cnt_d    = cnt_q;
      eval_s   = 1'b0;
      exc_ok_s = 1'b0;
      if (rst) begin
         ctrl_s  = ctrl_reset();
         state_d = ST_RUN;
         cnt_d   = {TO_W{1'b0}};
      end else begin
         case (state_q)
            ST_RUN: begin
               eval_s   = 1'b1;
               exc_ok_s = 1'b1;
            end
            ST_MEMWAIT: begin
               if (mem_ready) begin
                  // release cycle behaves like RUN except exceptions still wait
                  eval_s  = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  ctrl_s.pc_en        = 1'b0;
                  ctrl_s.if_id_en     = 1'b0;
                  ctrl_s.id_exe_en    = 1'b0;
                  ctrl_s.exe_mem_en   = 1'b0;
                  ctrl_s.mem_wb_flush = 1'b1;
                  if (cnt_q == TO_LAST) begin
                     ctrl_s.bus_err = 1'b1;
                     state_d        = ST_RUN;
                     cnt_d          = {TO_W{1'b0}};
                  end else begin
                     cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            ST_EXCFLUSH: begin
               ctrl_s.if_id_flush = 1'b1;
               state_d            = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
               cnt_d   = {TO_W{1'b0}};
            end
         endcase

         if (eval_s) begin
            if (exc_ok_s && exc_req) begin
               ctrl_s.if_id_flush   = 1'b1;
               ctrl_s.id_exe_flush  = 1'b1;
               ctrl_s.exe_mem_flush = 1'b1;
               ctrl_s.exc_ack       = 1'b1;
               state_d              = ST_EXCFLUSH;
            end else if (mem_req && !mem_ready) begin
               ctrl_s.pc_en        = 1'b0;
               ctrl_s.if_id_en     = 1'b0;
               ctrl_s.id_exe_en    = 1'b0;
               ctrl_s.exe_mem_en   = 1'b0;
               ctrl_s.mem_wb_flush = 1'b1;
               state_d             = ST_MEMWAIT;
               cnt_d               = {TO_W{1'b0}};
            end else if (exe_bj) begin
               ctrl_s.if_id_flush  = 1'b1;
               ctrl_s.id_exe_flush = 1'b1;
            end else if (lu_hit_s) begin
               ctrl_s.pc_en        = 1'b0;
               ctrl_s.if_id_en     = 1'b0;
               ctrl_s.id_exe_flush = 1'b1;
            end else begin
               ctrl_s.mem_wb_flush = 1'b0;
            end
         end else begin
            eval_s = 1'b0;
         end
      end
   end

   // State and timeout counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= {TO_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_en         = ctrl_s.pc_en;
   assign if_id_en      = ctrl_s.if_id_en;
   assign id_exe_en     = ctrl_s.id_exe_en;
   assign exe_mem_en    = ctrl_s.exe_mem_en;
   assign mem_wb_en     = ctrl_s.mem_wb_en;
   assign if_id_flush   = ctrl_s.if_id_flush;
   assign id_exe_flush  = ctrl_s.id_exe_flush;
   assign exe_mem_flush = ctrl_s.exe_mem_flush;
   assign mem_wb_flush  = ctrl_s.mem_wb_flush;
   assign exc_ack       = ctrl_s.exc_ack;
   assign bus_err       = ctrl_s.bus_err;

`ifdef PIPE_HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_q;
   logic [PERF_W-1:0] flush_q;
   logic              flush_evt_s;

   // Exception, EXCFLUSH and branch all squash IF/ID; load-use only touches ID/EXE
   assign flush_evt_s = ctrl_s.if_id_flush;

   // Free-running wrap-around performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= {PERF_W{1'b0}};
         flush_q <= {PERF_W{1'b0}};
      end else begin
         if (!ctrl_s.pc_en) begin
            stall_q <= stall_q + {{(PERF_W-1){1'b0}}, 1'b1};
         end else begin
            stall_q <= stall_q;
         end
         if (flush_evt_s) begin
            flush_q <= flush_q + {{(PERF_W-1){1'b0}}, 1'b1};
         end else begin
            flush_q <= flush_q;
         end
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   assign stall_cycles = {PERF_W{1'b0}};
   assign flush_events = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized run against a reference model.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs, id_rt, exe_wb_dreg;
   logic        id_use_rs, id_use_rt, exe_wb_we, exe_is_load, exe_bj;
   logic        exc_req, mem_req, mem_ready;
   logic        pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
   logic        if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
   logic        exc_ack, bus_err;
   logic [31:0] stall_cycles, flush_events;

   int tests_run    = 0;
   int tests_failed = 0;

   // order: pc, if_id_en, id_exe_en, exe_mem_en, mem_wb_en, 4 flushes, exc_ack, bus_err
   localparam logic [10:0] RUN_DEF = 11'b11111_0000_00;
   localparam logic [10:0] RST_OUT = 11'b00000_1111_00;
   localparam logic [10:0] LU_OUT  = 11'b00111_0100_00;
   localparam logic [10:0] BR_OUT  = 11'b11111_1100_00;
   localparam logic [10:0] FREEZE  = 11'b00001_0001_00;
   localparam logic [10:0] BERR    = 11'b00001_0001_01;
   localparam logic [10:0] EXC_OUT = 11'b11111_1110_10;
   localparam logic [10:0] EXCF    = 11'b11111_1000_00;
   localparam int          TIMEOUT = 4;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .TO_W(8), .PERF_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .exe_wb_dreg(exe_wb_dreg), .exe_wb_we(exe_wb_we), .exe_is_load(exe_is_load),
      .exe_bj(exe_bj), .exc_req(exc_req), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en), .exe_mem_en(exe_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
      .exe_mem_flush(exe_mem_flush), .mem_wb_flush(mem_wb_flush),
      .exc_ack(exc_ack), .bus_err(bus_err),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] obs();
      return {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
              if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush, exc_ack, bus_err};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
      exe_wb_dreg = 5'd0; exe_wb_we = 1'b0; exe_is_load = 1'b0; exe_bj = 1'b0;
      exc_req = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #1;
      tests_run++;
      if (obs() !== RST_OUT) begin
         tests_failed++; $display("FAIL reset_outputs: got %b expected %b", obs(), RST_OUT);
      end
      tick();
      tests_run++;
      if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
         tests_failed++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", stall_cycles, flush_events);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (obs() !== RUN_DEF) begin
         tests_failed++; $display("FAIL reset_release: got %b expected %b", obs(), RUN_DEF);
      end
      tick();
   endtask

   task automatic test_loaduse();
      idle_inputs();
      exe_is_load = 1'b1; exe_wb_we = 1'b1; exe_wb_dreg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
      #1;
      tests_run++;
      if (obs() !== LU_OUT) begin
         tests_failed++; $display("FAIL loaduse_stall: got %b expected %b", obs(), LU_OUT);
      end
      tick();
      exe_is_load = 1'b0; exe_wb_we = 1'b0; exe_wb_dreg = 5'd0;
      #1;
      tests_run++;
      if (obs() !== RUN_DEF) begin
         tests_failed++; $display("FAIL loaduse_after_bubble: got %b expected %b", obs(), RUN_DEF);
      end
      tick();
      exe_is_load = 1'b1; exe_wb_we = 1'b1; exe_wb_dreg = 5'd13; id_rs = 5'd2; id_rt = 5'd13;
      id_use_rs = 1'b1; id_use_rt = 1'b1;
      #1;
      tests_run++;
      if (obs() !== LU_OUT) begin
         tests_failed++; $display("FAIL loaduse_rt: got %b expected %b", obs(), LU_OUT);
      end
      tick();
   endtask

   task automatic test_no_stall();
      idle_inputs();
      exe_is_load = 1'b1; exe_wb_we = 1'b1; exe_wb_dreg = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
      #1;
      tests_run++;
      if (obs() !== RUN_DEF) begin
         tests_failed++; $display("FAIL nostall_reg0: got %b expected %b", obs(), RUN_DEF);
      end
      tick();
      exe_wb_dreg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b0;
      #1;
      tests_run++;
      if (obs() !== RUN_DEF) begin
         tests_failed++; $display("FAIL nostall_unused_rs: got %b expected %b", obs(), RUN_DEF);
      end
      tick();
   endtask

   task automatic test_branch_priority();
      idle_inputs();
      exe_is_load = 1'b1; exe_wb_we = 1'b1; exe_wb_dreg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
      exe_bj = 1'b1;
      #1;
      tests_run++;
      if (obs() !== BR_OUT) begin
         tests_failed++; $display("FAIL branch_over_loaduse: got %b expected %b", obs(), BR_OUT);
      end
      tick();
   endtask

   task automatic test_memwait();
      idle_inputs();
      mem_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         exc_req = (c == 2);
         #1;
         tests_run++;
         if (obs() !== FREEZE) begin
            tests_failed++; $display("FAIL memwait_freeze[%0d]: got %b expected %b", c, obs(), FREEZE);
         end
         tick();
      end
      exc_req = 1'b0; mem_ready = 1'b1;
      #1;
      tests_run++;
      if (obs() !== RUN_DEF) begin
         tests_failed++; $display("FAIL memwait_release: got %b expected %b", obs(), RUN_DEF);
      end
      tick();
      idle_inputs();
      #1;
      tests_run++;
      if (obs() !== RUN_DEF) begin
         tests_failed++; $display("FAIL memwait_back_in_run: got %b expected %b", obs(), RUN_DEF);
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [31:0] s0;
      idle_inputs();
      mem_req = 1'b1;
      #1;
      s0 = stall_cycles;
      for (int c = 0; c < TIMEOUT + 1; c++) begin
         tests_run++;
         if (obs() !== ((c == TIMEOUT) ? BERR : FREEZE)) begin
            tests_failed++;
            $display("FAIL timeout_cycle[%0d]: got %b expected %b", c, obs(), (c == TIMEOUT) ? BERR : FREEZE);
         end
         tick();
      end
`ifdef PIPE_HAZARD_PERF_EN
      tests_run++;
      if (stall_cycles - s0 !== 32'd5) begin
         tests_failed++; $display("FAIL timeout_stall_count: got %0d expected 5", stall_cycles - s0);
      end
`else
      tests_run++;
      if (stall_cycles !== 32'd0 || s0 !== 32'd0) begin
         tests_failed++; $display("FAIL perf_tied_off: got %0d expected 0", stall_cycles);
      end
`endif
      tests_run++;
      if (obs() !== FREEZE) begin
         tests_failed++; $display("FAIL timeout_single_pulse: got %b expected %b", obs(), FREEZE);
      end
      tick();
      mem_ready = 1'b1;
      #1;
      tick();
      idle_inputs();
   endtask

   task automatic test_exception();
      idle_inputs();
      exc_req = 1'b1;
      #1;
      tests_run++;
      if (obs() !== EXC_OUT) begin
         tests_failed++; $display("FAIL exc_take: got %b expected %b", obs(), EXC_OUT);
      end
      tick();
      tests_run++;
      if (obs() !== EXCF) begin
         tests_failed++; $display("FAIL exc_flush_cycle: got %b expected %b", obs(), EXCF);
      end
      tick();
      exc_req = 1'b0;
      #1;
      tests_run++;
      if (obs() !== RUN_DEF) begin
         tests_failed++; $display("FAIL exc_return_run: got %b expected %b", obs(), RUN_DEF);
      end
      tick();
      mem_req = 1'b1;
      #1;
      tick();
      rst = 1'b1;
      #1;
      tests_run++;
      if (obs() !== RST_OUT) begin
         tests_failed++; $display("FAIL rst_in_memwait: got %b expected %b", obs(), RST_OUT);
      end
      tick();
      rst = 1'b0; mem_req = 1'b0;
      #1;
      tests_run++;
      if (obs() !== RUN_DEF) begin
         tests_failed++; $display("FAIL rst_abandons_memwait: got %b expected %b", obs(), RUN_DEF);
      end
      tests_run++;
      if (stall_cycles !== 32'd0) begin
         tests_failed++; $display("FAIL rst_clears_perf: got %0d expected 0", stall_cycles);
      end
      tick();
   endtask

   task automatic test_random();
      bit          m_wait, m_exc, n_wait, n_exc, lu, stall_now, flush_now;
      int          m_cnt, n_cnt;
      logic [31:0] m_stall, m_flush;
      logic [10:0] exp;
      m_wait = 1'b0; m_exc = 1'b0; m_cnt = 0; m_stall = 32'd0; m_flush = 32'd0;
      for (int i = 0; i < 600; i++) begin
         rst         = (i == 0) || ($urandom_range(0, 59) == 0);
         exc_req     = ($urandom_range(0, 7) == 0);
         mem_req     = ($urandom_range(0, 2) == 0);
         mem_ready   = ($urandom_range(0, 3) == 0);
         exe_bj      = ($urandom_range(0, 5) == 0);
         exe_is_load = $urandom_range(0, 1) == 1;
         exe_wb_we   = $urandom_range(0, 3) != 0;
         exe_wb_dreg = 5'($urandom_range(0, 3));
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         id_use_rs   = $urandom_range(0, 1) == 1;
         id_use_rt   = $urandom_range(0, 1) == 1;
         #1;
         if (i > 0) begin
            tests_run++;
            if (stall_cycles !== m_stall || flush_events !== m_flush) begin
               tests_failed++;
               $display("FAIL rand_perf[%0d]: got %0d/%0d expected %0d/%0d",
                        i, stall_cycles, flush_events, m_stall, m_flush);
            end
         end
         lu = exe_is_load && exe_wb_we && exe_wb_dreg != 5'd0 &&
              ((id_use_rs && id_rs == exe_wb_dreg) || (id_use_rt && id_rt == exe_wb_dreg));
         exp = RUN_DEF; n_wait = m_wait; n_exc = m_exc; n_cnt = m_cnt; flush_now = 1'b0;
         if (rst) begin
            exp = RST_OUT; n_wait = 1'b0; n_exc = 1'b0; n_cnt = 0;
         end else if (m_exc) begin
            exp = EXCF; n_exc = 1'b0; flush_now = 1'b1;
         end else if (m_wait && !mem_ready) begin
            n_cnt = m_cnt + 1;
            if (n_cnt == TIMEOUT) begin
               exp = BERR; n_wait = 1'b0;
            end else begin
               exp = FREEZE;
            end
         end else begin
            n_wait = 1'b0;
            if (!m_wait && exc_req) begin
               exp = EXC_OUT; n_exc = 1'b1; flush_now = 1'b1;
            end else if (mem_req && !mem_ready) begin
               exp = FREEZE; n_wait = 1'b1; n_cnt = 0;
            end else if (exe_bj) begin
               exp = BR_OUT; flush_now = 1'b1;
            end else if (lu) begin
               exp = LU_OUT;
            end
         end
         tests_run++;
         if (obs() !== exp) begin
            tests_failed++; $display("FAIL rand_outputs[%0d]: got %b expected %b", i, obs(), exp);
         end
         stall_now = !rst && (exp == LU_OUT || exp == FREEZE || exp == BERR);
`ifdef PIPE_HAZARD_PERF_EN
         if (rst) begin
            m_stall = 32'd0; m_flush = 32'd0;
         end else begin
            m_stall = m_stall + (stall_now ? 32'd1 : 32'd0);
            m_flush = m_flush + (flush_now ? 32'd1 : 32'd0);
         end
`else
         if (stall_now && flush_now) m_stall = 32'd0;
`endif
         tick();
         m_wait = n_wait; m_exc = n_exc; m_cnt = n_cnt;
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      #1;
      test_reset();
      test_loaduse();
      test_no_stall();
      test_branch_priority();
      test_memwait();
      test_timeout();
      test_exception();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
